// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller slice.
// Holds the state encoding, default digit geometry and the limit-word helper.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    PAUSE    = 3'd2,
    LAP_RUN  = 3'd3,
    LAP_HOLD = 3'd4
  } state_t;

  localparam int DEFAULT_NUMBER_OF_DIGITS         = 4;
  localparam int DEFAULT_NUMBER_OF_BITS_PER_DIGIT = 4;
  localparam int DEFAULT_DIGIT_MAX                = 9;

  localparam int MAX_WORD_BITS = 64;

  // Builds the count word with every digit at its maximum value.
  function automatic logic [MAX_WORD_BITS-1:0] limit_word(
    input int digits,
    input int bits,
    input int digit_max
  );
    logic [MAX_WORD_BITS-1:0] word;
    logic [MAX_WORD_BITS-1:0] digit_mask;
    word       = '0;
    digit_mask = (MAX_WORD_BITS'(1) << bits) - MAX_WORD_BITS'(1);
    for (int i = 0; i < digits; i++) begin
      word = word | ((MAX_WORD_BITS'(digit_max) & digit_mask) << (i * bits));
    end
    return word;
  endfunction

endpackage

// File: rtl/stopwatch_controller_rise_edge_detect.sv
// Single-bit rising-edge detector for an already synchronized, debounced level.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_q <= 1'b0;
    end else begin
      edge_q <= level;
    end
  end

  assign rise = level & ~edge_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: turns button edges into counter enable,
// direction and clear, and chooses between the live count and a frozen lap value.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int NUMBER_OF_DIGITS         = DEFAULT_NUMBER_OF_DIGITS,
  parameter int NUMBER_OF_BITS_PER_DIGIT = DEFAULT_NUMBER_OF_BITS_PER_DIGIT,
  parameter int DIGIT_MAX                = DEFAULT_DIGIT_MAX
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         btn_start_stop,
  input  logic                                         btn_lap,
  input  logic                                         btn_clear,
  input  logic                                         dir_up,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] count_value,
  output logic                                         cnt_enable,
  output logic                                         cnt_up_down,
  output logic                                         cnt_clear,
  output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] display_number,
  output logic                                         running,
  output logic                                         lap_active,
  output logic                                         limit_hit
);

  localparam int WORD_BITS = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam logic [MAX_WORD_BITS-1:0] LIMIT_FULL =
    limit_word(NUMBER_OF_DIGITS, NUMBER_OF_BITS_PER_DIGIT, DIGIT_MAX);
  localparam logic [WORD_BITS-1:0] LIMIT_UP = LIMIT_FULL[WORD_BITS-1:0];

  logic ss_rise;
  logic lap_rise;
  logic clr_rise;

  logic ss_evt;
  logic lap_evt;
  logic clr_evt;

  logic at_limit;

  state_t state;
  state_t state_next;
  logic   capture_lap;
  logic   clear_pulse;
  logic   limit_pulse;

  logic [WORD_BITS-1:0] lap_reg;
  logic                 dir_reg;

  rise_edge_detect u_edge_start_stop (
    .clk   (clk),
    .rst   (rst),
    .level (btn_start_stop),
    .rise  (ss_rise)
  );

  rise_edge_detect u_edge_lap (
    .clk   (clk),
    .rst   (rst),
    .level (btn_lap),
    .rise  (lap_rise)
  );

  rise_edge_detect u_edge_clear (
    .clk   (clk),
    .rst   (rst),
    .level (btn_clear),
    .rise  (clr_rise)
  );

  // Only the highest-priority edge of a cycle survives; the rest are dropped.
  always_comb begin
    clr_evt = clr_rise;
    ss_evt  = ss_rise & ~clr_rise;
    lap_evt = lap_rise & ~clr_rise & ~ss_rise;
  end

  always_comb begin
    if (dir_reg) begin
      at_limit = (count_value == LIMIT_UP);
    end else begin
      at_limit = (count_value == '0);
    end
  end

  always_comb begin
    state_next  = state;
    capture_lap = 1'b0;
    clear_pulse = 1'b0;
    limit_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (clr_evt) begin
          clear_pulse = 1'b1;
        end else if (ss_evt && !at_limit) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // Reaching the limit outranks any button, including a redundant stop.
        if (at_limit) begin
          state_next  = PAUSE;
          limit_pulse = 1'b1;
        end else if (ss_evt) begin
          state_next = PAUSE;
        end else if (lap_evt) begin
          state_next  = LAP_RUN;
          capture_lap = 1'b1;
        end
      end
      LAP_RUN: begin
        if (at_limit) begin
          state_next  = LAP_HOLD;
          limit_pulse = 1'b1;
        end else if (ss_evt) begin
          state_next = LAP_HOLD;
        end else if (lap_evt) begin
          capture_lap = 1'b1;
        end
      end
      PAUSE: begin
        if (clr_evt) begin
          state_next  = IDLE;
          clear_pulse = 1'b1;
        end else if (ss_evt && !at_limit) begin
          state_next = RUN;
        end
      end
      LAP_HOLD: begin
        if (clr_evt) begin
          state_next  = IDLE;
          clear_pulse = 1'b1;
        end else if (ss_evt && !at_limit) begin
          state_next = LAP_RUN;
        end else if (lap_evt) begin
          state_next = PAUSE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Direction is only tracked while idle, so it is frozen for a whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      lap_reg        <= '0;
      dir_reg        <= 1'b1;
      cnt_enable     <= 1'b0;
      cnt_clear      <= 1'b0;
      display_number <= '0;
      running        <= 1'b0;
      lap_active     <= 1'b0;
      limit_hit      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        dir_reg <= dir_up;
      end
      if (capture_lap) begin
        lap_reg <= count_value;
      end
      cnt_enable <= (state_next == RUN) || (state_next == LAP_RUN);
      running    <= (state_next == RUN) || (state_next == LAP_RUN);
      lap_active <= (state_next == LAP_RUN) || (state_next == LAP_HOLD);
      cnt_clear  <= clear_pulse;
      limit_hit  <= limit_pulse;
      if ((state == LAP_RUN) || (state == LAP_HOLD)) begin
        display_number <= lap_reg;
      end else begin
        display_number <= count_value;
      end
    end
  end

  assign cnt_up_down = dir_reg;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller: directed button/count sequences
// queue expected outputs, and a negedge monitor pops and compares them.
module tb_stopwatch_controller;

  logic        clk;
  logic        rst;
  logic        btn_start_stop;
  logic        btn_lap;
  logic        btn_clear;
  logic        dir_up;
  logic [15:0] count_value;
  logic        cnt_enable;
  logic        cnt_up_down;
  logic        cnt_clear;
  logic [15:0] display_number;
  logic        running;
  logic        lap_active;
  logic        limit_hit;

  typedef struct {
    string       name;
    logic        en;
    logic        ud;
    logic        clr;
    logic [15:0] disp;
    logic        run;
    logic        lap;
    logic        lim;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  stopwatch_controller #(
    .NUMBER_OF_DIGITS         (4),
    .NUMBER_OF_BITS_PER_DIGIT (4),
    .DIGIT_MAX                (9)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .dir_up         (dir_up),
    .count_value    (count_value),
    .cnt_enable     (cnt_enable),
    .cnt_up_down    (cnt_up_down),
    .cnt_clear      (cnt_clear),
    .display_number (display_number),
    .running        (running),
    .lap_active     (lap_active),
    .limit_hit      (limit_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs and returns just after the edge that samples them.
  task automatic applyStimulus(input logic ss, input logic lap, input logic clr,
                               input logic dir, input logic [15:0] cv);
    btn_start_stop = ss;
    btn_lap        = lap;
    btn_clear      = clr;
    dir_up         = dir;
    count_value    = cv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic en, input logic ud,
                             input logic clr, input logic [15:0] disp,
                             input logic run, input logic lap, input logic lim);
    exp_t e;
    e.name = name;
    e.en   = en;
    e.ud   = ud;
    e.clr  = clr;
    e.disp = disp;
    e.run  = run;
    e.lap  = lap;
    e.lim  = lim;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (cnt_enable !== e.en || cnt_up_down !== e.ud || cnt_clear !== e.clr ||
          display_number !== e.disp || running !== e.run ||
          lap_active !== e.lap || limit_hit !== e.lim) begin
        errors++;
        $display("[TB] FAIL %s: got en=%0b ud=%0b clr=%0b disp=%h run=%0b lap=%0b lim=%0b, expected en=%0b ud=%0b clr=%0b disp=%h run=%0b lap=%0b lim=%0b",
                 e.name, cnt_enable, cnt_up_down, cnt_clear, display_number,
                 running, lap_active, limit_hit, e.en, e.ud, e.clr, e.disp,
                 e.run, e.lap, e.lim);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
    dir_up         = 1'b1;
    count_value    = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 1, 0, 16'h0000, 0, 0, 0);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkOutput("idle", 0, 1, 0, 16'h0000, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 16'h0000);
    checkOutput("start", 1, 1, 0, 16'h0000, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h0123);
    checkOutput("run_live", 1, 1, 0, 16'h0123, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 16'h0123);
    checkOutput("lap_capture", 1, 1, 0, 16'h0123, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 16'h0130);
    checkOutput("lap_frozen", 1, 1, 0, 16'h0123, 1, 1, 0);
    applyStimulus(0, 1, 0, 1, 16'h0130);
    checkOutput("lap_recapture_latency", 1, 1, 0, 16'h0123, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 16'h0131);
    checkOutput("lap_second", 1, 1, 0, 16'h0130, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 16'h0131);
    checkOutput("lap_hold", 0, 1, 0, 16'h0130, 0, 1, 0);
    applyStimulus(0, 1, 0, 1, 16'h0131);
    checkOutput("hold_to_pause", 0, 1, 0, 16'h0130, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h0131);
    checkOutput("pause_live", 0, 1, 0, 16'h0131, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 16'h0131);
    checkOutput("resume", 1, 1, 0, 16'h0131, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h9999);
    checkOutput("auto_stop", 0, 1, 0, 16'h9999, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 16'h9999);
    checkOutput("limit_pulse_end", 0, 1, 0, 16'h9999, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 16'h9999);
    checkOutput("start_at_limit_ignored", 0, 1, 0, 16'h9999, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h9999);
    applyStimulus(1, 1, 1, 1, 16'h9999);
    checkOutput("clear_combo", 0, 1, 1, 16'h9999, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkOutput("clear_pulse_end", 0, 1, 0, 16'h0000, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkOutput("dir_down_idle", 0, 0, 0, 16'h0000, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkOutput("start_at_zero_ignored", 0, 0, 0, 16'h0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 16'h0005);
    applyStimulus(1, 0, 0, 0, 16'h0005);
    checkOutput("start_down", 1, 0, 0, 16'h0005, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h0004);
    checkOutput("dir_locked", 1, 0, 0, 16'h0004, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 16'h0004);
    checkOutput("lap_down", 1, 0, 0, 16'h0004, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 16'h0003);
    checkOutput("lap_down_frozen", 1, 0, 0, 16'h0004, 1, 1, 0);

    // Pulse reset between clock edges so only an asynchronous reset can take it.
    @(negedge clk);
    #1;
    count_value = 16'h0000;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_reset", 0, 1, 0, 16'h0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkOutput("after_release", 0, 1, 0, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      errors = errors + sb_q.size();
      checks = checks + sb_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
